// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch front end and the
// Controller/decode side.
//   AW            instruction address width (64-word instruction memory)
//   DW            instruction width
//   NOP_INST      word presented to decode when no instruction is valid
//                 (opcode field [18:15] = 4'b1111, no register write)
//   fetch_entry_t {pc, inst} pair held in the prefetch FIFO
package fetch_pkg;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam logic [DW-1:0] NOP_INST = 32'h0007_8000;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: pointer-based synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, din    write din at the tail (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   flush        empty the FIFO; overrides push and pop in the same edge
//   head         current head entry (undefined when empty)
//   count        number of stored entries, 0..DEPTH
//   empty, full  status flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed behind count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues reads to a 1-cycle-latency synchronous
// instruction memory, buffers returned words in a prefetch FIFO and hands
// them to decode over valid/ready. A redirect flushes buffered and
// in-flight words and restarts fetch at redirect_pc.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   fetch_en        allow new reads (buffered words drain regardless)
//   imem_en         read strobe; imem_addr is always the fetch PC
//   imem_rdata      read data, valid the cycle after imem_en was sampled
//   redirect_valid  one-cycle pulse loading redirect_pc as the fetch PC
//   inst_valid      head entry available on inst_data / inst_pc
//   inst_ready      decode accepts the head when inst_valid & inst_ready
//   inst_data       head word, NOP_INST when not valid
//   inst_pc         head address, 0 when not valid
//   fifo_count      buffered entry count (debug)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  output logic [CW-1:0] fifo_count
);

  logic [AW-1:0] pc;
  logic [AW-1:0] issued_pc;
  logic          inflight;
  logic [CW:0]   credit_used;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_head;

  // Reserve a slot for the word already in flight; a pop in the same
  // cycle is not credited, so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};

  // Gated by rst so no read strobe escapes while reset is held.
  assign imem_en = rst & fetch_en & ~redirect_valid & ~fifo_full
                 & (credit_used < (CW+1)'(DEPTH));

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      issued_pc <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) issued_pc <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (imem_en)   pc <= pc + AW'(1);
    end
  end

  // A redirect discards the returning word and wins over a pop.
  assign fifo_push     = inflight & ~redirect_valid;
  assign fifo_pop      = inst_valid & inst_ready & ~redirect_valid;
  assign fifo_din.pc   = issued_pc;
  assign fifo_din.inst = imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_data  = inst_valid ? fifo_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP  = 32'h0007_8000;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [5:0]  inst_pc;
  logic [2:0]  fifo_count;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word k = BASE + k, one cycle latency.
  always @(posedge clk) if (imem_en) imem_rdata <= BASE + 32'(imem_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: fetch PC, one outstanding read, queue of buffered pcs.
  int m_pc = 0;
  int m_inflight = 0;
  int m_ipc = 0;
  int q[$];
  int popped[$];
  bit obs_en, obs_valid;
  int obs_addr, obs_pc, obs_count;

  task automatic model_reset();
    m_pc = 0; m_inflight = 0; m_ipc = 0; q.delete();
  endtask

  // Drive one cycle's inputs, compare all outputs, then advance the model
  // across the clock edge. Entered and left 1 time unit after a rising edge.
  task automatic step(input bit fe, input bit rdy, input bit rv, input int rpc);
    bit exp_en, exp_valid, pop;
    int exp_pc, old_pc;
    fetch_en = fe; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc[5:0];
    #2;
    exp_en    = fe && !rv && (q.size() + m_inflight < DEPTH);
    exp_valid = q.size() > 0;
    exp_pc    = exp_valid ? q[0] : 0;
    chk("imem_en",    imem_en,    exp_en);
    chk("imem_addr",  imem_addr,  m_pc);
    chk("inst_valid", inst_valid, exp_valid);
    chk("inst_pc",    inst_pc,    exp_pc);
    chk("inst_data",  inst_data,  exp_valid ? BASE + 32'(exp_pc) : NOP);
    chk("fifo_count", fifo_count, q.size());
    obs_en = imem_en; obs_valid = inst_valid; obs_addr = imem_addr;
    obs_pc = inst_pc; obs_count = fifo_count;
    if (inst_valid && rdy && !rv) popped.push_back(int'(inst_pc));
    @(posedge clk);
    pop    = q.size() > 0 && rdy && !rv;
    old_pc = m_pc;
    if (rv) begin
      q.delete();
      m_pc = rpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_inflight != 0) q.push_back(m_ipc);
      if (exp_en) m_pc = (m_pc + 1) % 64;
    end
    m_inflight = exp_en ? 1 : 0;
    if (exp_en) m_ipc = old_pc;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin : main
    int first_valid;
    int gaps;
    bit found;

    // Reset state
    fetch_en = 1'b1; inst_ready = 1'b1;
    #2;
    chk("rst_imem_en",    imem_en,    0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data",  inst_data,  NOP);
    chk("rst_inst_pc",    inst_pc,    0);
    chk("rst_fifo_count", fifo_count, 0);
    model_reset();
    release_reset();

    // Streaming with ready held high
    first_valid = -1;
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      if (i == 0) chk("first_issue", {31'b0, obs_en}, 1);
      if (obs_valid && first_valid < 0) first_valid = i;
    end
    chk("first_valid_cycle", first_valid, 2);
    for (int i = 0; i < 6 && i < popped.size(); i++) chk("stream_pc", popped[i], i);

    // Back-pressure: FIFO saturates, no issue while full
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("sat_count", obs_count, DEPTH);
    chk("sat_imem_en", {31'b0, obs_en}, 0);
    popped.delete();
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    gaps = 0;
    for (int i = 1; i < popped.size(); i++)
      if (popped[i] != (popped[i-1] + 1) % 64) gaps++;
    chk("release_no_gap", gaps, 0);
    chk("release_deliv", popped.size() >= 10, 1);

    // Redirect to 40 with count=3 and a read in flight
    step(1, 0, 1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (q.size() == 3 && m_inflight == 1) found = 1;
      else step(1, 0, 0, 0);
    end
    chk("reach_cnt3_inflight", found, 1);
    step(1, 0, 1, 40);
    step(1, 1, 0, 0);
    chk("redir_count0", obs_count, 0);
    chk("redir_addr40", obs_addr, 40);
    step(1, 1, 0, 0);
    chk("redir_no_stale", {31'b0, obs_valid}, 0);
    step(1, 1, 0, 0);
    chk("redir_valid_t2", {31'b0, obs_valid}, 1);
    chk("redir_pc40", obs_pc, 40);

    // Wrap-around: redirect to 62
    popped.delete();
    step(1, 1, 1, 62);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    chk("wrap_len", popped.size() >= 4, 1);
    if (popped.size() >= 4) begin
      chk("wrap_0", popped[0], 62);
      chk("wrap_1", popped[1], 63);
      chk("wrap_2", popped[2], 0);
      chk("wrap_3", popped[3], 1);
    end

    // Redirect in the same cycle as a pop: flush wins
    chk("pre_pop_valid", {31'b0, inst_valid}, 1);
    popped.delete();
    step(1, 1, 1, 20);
    chk("redir_pop_ignored", popped.size(), 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    chk("redir_pop_first", popped.size() > 0 ? popped[0] : -1, 20);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 11) == 0, int'($urandom_range(0, 63)));

    // Asynchronous reset mid-cycle with two entries buffered
    step(1, 0, 1, 10);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (q.size() == 2) found = 1;
      else step(1, 0, 0, 0);
    end
    chk("reach_cnt2", found, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_inst_data",  inst_data,  NOP);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_inst_pc",    inst_pc,    0);
    chk("arst_imem_en",    imem_en,    0);
    model_reset();
    @(posedge clk);
    release_reset();
    step(1, 1, 0, 0);
    chk("restart_addr0", obs_addr, 0);
    chk("restart_en", {31'b0, obs_en}, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
